// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller.
// Contents: default opcode width, opcode constants, FSM state encoding,
// requester ID constants and the execution counter width.
package alu_pkg;

  localparam int OPW_DEF = 3;
  localparam int CNT_W   = 4;

  // Opcodes understood by the shared ALU
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter for the ALU sharing controller.
// Build option: ALU_SHARE_FIXED_PRIO_EN selects fixed priority (requester 0
// wins ties, last_grant ignored); otherwise ties go to the requester that was
// not granted last (round-robin).
// Ports:
//   valid[1:0]  in   request valids, bit N = requester N
//   last_grant  in   ID of the most recently granted requester
//   enable      in   arbitration allowed (controller idle)
//   grant[1:0]  out  one-hot grant, zero when nothing granted
//   grant_id    out  ID of the granted requester (REQ0 when no grant)
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic [1:0] grant_s;
  logic       grant_id_s;

  // Combinational grant selection
  always_comb begin
    grant_s    = 2'b00;
    grant_id_s = REQ0;
    if (enable) begin
      case (valid)
        2'b01: begin
          grant_id_s = REQ0;
          grant_s    = 2'b01;
        end
        2'b10: begin
          grant_id_s = REQ1;
          grant_s    = 2'b10;
        end
        2'b11: begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
          grant_id_s = REQ0;
`else
          grant_id_s = ~last_grant;
`endif
          grant_s    = (grant_id_s == REQ1) ? 2'b10 : 2'b01;
        end
        default: begin
          grant_id_s = REQ0;
          grant_s    = 2'b00;
        end
      endcase
    end else begin
      grant_id_s = REQ0;
      grant_s    = 2'b00;
    end
  end

  assign grant    = grant_s;
  assign grant_id = grant_id_s;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two valid/ready requesters. The winning operands and
// opcode are registered onto the ALU inputs, held for EXEC_CYCLES cycles, then
// the ALU result is captured and returned on a valid/ready response channel
// tagged with the requester ID.
// Build option: ALU_SHARE_FIXED_PRIO_EN (fixed priority to requester 0 on
// ties, no last_grant state); default is round-robin.
// Ports:
//   Clk, Rst                    clock, synchronous active-high reset
//   reqN_valid/ready            request handshake for requester N
//   reqN_a, reqN_b, reqN_op     requester N operands and opcode
//   alu_a, alu_b, alu_op        registered ALU inputs
//   alu_res                     ALU result
//   rsp_valid/ready             response handshake
//   rsp_data, rsp_id            captured result and issuing requester
//   busy                        high whenever the controller is not idle
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int OPW         = OPW_DEF,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  // Counter value on the final EXEC cycle
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [OPW-1:0]   alu_op_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_id_r;
  logic             busy_r;
  logic             last_grant_s;

  logic [1:0]       grant_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [OPW-1:0]   sel_op_s;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  assign last_grant_s = REQ1;
`else
  logic last_grant_r;

  // Remember the last granted requester for round-robin tie breaking
  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_grant_r <= REQ1;
    end else if ((state_r == IDLE) && accept_s) begin
      last_grant_r <= grant_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign last_grant_s = last_grant_r;
`endif

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_s),
    .enable     (state_r == IDLE),
    .grant      (grant_s),
    .grant_id   (grant_id_s)
  );

  // A grant always implies the matching valid, so any grant is an accept
  assign accept_s   = (grant_s != 2'b00);
  assign req0_ready = grant_s[0];
  assign req1_ready = grant_s[1];

  assign sel_a_s  = (grant_id_s == REQ1) ? req1_a  : req0_a;
  assign sel_b_s  = (grant_id_s == REQ1) ? req1_b  : req0_b;
  assign sel_op_s = (grant_id_s == REQ1) ? req1_op : req0_op;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == EXEC_LAST) begin
          state_s = RESP;
        end else begin
          state_s = EXEC;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand capture, execution counter and response registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_op_r    <= {OPW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {WIDTH{1'b0}};
      rsp_id_r    <= REQ0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_a_r  <= sel_a_s;
            alu_b_r  <= sel_b_s;
            alu_op_r <= sel_op_s;
            rsp_id_r <= grant_id_s;
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        EXEC: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == EXEC_LAST) begin
            rsp_data_r  <= alu_res;
            rsp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = busy_r;

endmodule
